// File: rtl/imm_ext_queue.sv
// rtl/imm_ext_queue.sv - Immediate extender feeding a DEPTH-entry output FIFO
//
// Purpose:
//   Takes a raw 32-bit instruction and a format selector through a valid/ready
//   handshake. It extends the immediate to XLEN bits and queues the result for
//   the execute-stage operand mux. A stall in decode and backpressure from
//   execute are decoupled by the FIFO.
//
// Parameters:
//   XLEN  - immediate width, 32 or 64
//   DEPTH - FIFO entries, a power of two and >= 2
//
// Optional feature (macro IMM_EXT_ILLEGAL_CHK_EN):
//   When the macro is defined, each entry stores an error bit. The bit is set
//   for selector 000/111, and for a shift-imm with instr[25]=1 when XLEN=32.
//   Such entries carry an immediate of 0.
//   When the macro is undefined, out_err is tied low.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset
//   in_valid  in   instruction/selector valid
//   in_ready  out  block can accept this cycle (count != DEPTH)
//   in_instr  in   [31:0] raw instruction word
//   in_sel    in   [2:0] 001 I, 010 S, 011 B, 100 U, 101 J, 110 shift-imm
//   out_valid out  FIFO head valid (count != 0)
//   out_ready in   consumer accepts head
//   out_imm   out  [XLEN-1:0] extended immediate at FIFO head
//   out_err   out  head entry flagged illegal
//   count     out  [$clog2(DEPTH):0] FIFO occupancy
module imm_ext_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [2:0]               in_sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_imm,
    output logic                     out_err,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] SEL_I     = 3'b001;
    localparam logic [2:0] SEL_S     = 3'b010;
    localparam logic [2:0] SEL_B     = 3'b011;
    localparam logic [2:0] SEL_U     = 3'b100;
    localparam logic [2:0] SEL_J     = 3'b101;
    localparam logic [2:0] SEL_SHIFT = 3'b110;

    // Opcode bits never take part in any immediate format.
    logic unused_opcode;
    assign unused_opcode = ^in_instr[6:0];

    // ------------------------------------------------------------------
    // Combinational extension
    // ------------------------------------------------------------------
    // Every format is first formed as a sign-extended 32-bit value. A single
    // signed cast then widens it to XLEN. The shift amount is zero-extended
    // into raw32, so its bit 31 is always 0 and the widening is a no-op.
    logic [31:0]     raw32;
    logic [XLEN-1:0] ext_imm;
    logic            ext_err;

    always_comb begin
        raw32   = '0;
        ext_err = 1'b0;
        unique case (in_sel)
            SEL_I: raw32 = {{20{in_instr[31]}}, in_instr[31:20]};
            SEL_S: raw32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            SEL_B: raw32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                            in_instr[30:25], in_instr[11:8], 1'b0};
            SEL_U: raw32 = {in_instr[31:12], 12'b0};
            SEL_J: raw32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21], 1'b0};
            SEL_SHIFT: begin
                if (XLEN == 64) begin
                    raw32 = {26'b0, in_instr[25:20]};
                end else begin
                    raw32 = {27'b0, in_instr[24:20]};
`ifdef IMM_EXT_ILLEGAL_CHK_EN
                    // In RV32, a shamt with bit 5 set is reserved.
                    if (in_instr[25]) begin
                        raw32   = '0;
                        ext_err = 1'b1;
                    end
`endif
                end
            end
            default: begin
                raw32   = '0;
`ifdef IMM_EXT_ILLEGAL_CHK_EN
                ext_err = 1'b1;
`endif
            end
        endcase
        ext_imm = XLEN'($signed(raw32));
    end

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [XLEN-1:0] mem_imm_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic            push, pop;

    assign in_ready  = !reset && (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;
    assign out_imm   = mem_imm_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // The storage is cleared on reset, so the head reads 0 right after reset
    // and no stale entry can reappear once reset is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                mem_imm_q[k] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                mem_imm_q[wr_ptr_q] <= ext_imm;
            end
        end
    end

`ifdef IMM_EXT_ILLEGAL_CHK_EN
    logic [DEPTH-1:0] mem_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_err_q <= '0;
        end else if (push) begin
            mem_err_q[wr_ptr_q] <= ext_err;
        end
    end

    assign out_err = mem_err_q[rd_ptr_q];
`else
    logic unused_err;
    assign unused_err = ext_err;
    assign out_err    = 1'b0;
`endif

endmodule

// File: tb/tb_imm_ext_queue.sv
// tb/tb_imm_ext_queue.sv - Self-checking bench for imm_ext_queue
module tb_imm_ext_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [2:0]      in_sel;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic            out_err;
    logic [CW-1:0]   count;

    int vectors = 0;
    int errors  = 0;

    imm_ext_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_err   (out_err),
        .count     (count)
    );

    always #5 clk = ~clk;

    // Reference extension computed with signed arithmetic on instruction fields.
    function automatic logic [XLEN:0] ref_ext(input logic [31:0] i, input logic [2:0] s);
        longint v;
        longint top;
        logic   err;
        top = int'(i) >>> 31;
        err = 1'b0;
        v   = 0;
        case (s)
            3'd1: v = int'(i) >>> 20;
            3'd2: v = (int'(i) >>> 25) * 32 + longint'(i[11:7]);
            3'd3: v = top * 4096 + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32
                      + longint'(i[11:8]) * 2;
            3'd4: v = int'(i & 32'hFFFF_F000);
            3'd5: v = top * 1048576 + longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048
                      + longint'(i[30:21]) * 2;
            3'd6: begin
                if (XLEN == 64) v = longint'(i[25:20]);
                else            v = longint'(i[24:20]);
`ifdef IMM_EXT_ILLEGAL_CHK_EN
                if (XLEN == 32 && i[25]) begin
                    v   = 0;
                    err = 1'b1;
                end
`endif
            end
            default: begin
                v = 0;
`ifdef IMM_EXT_ILLEGAL_CHK_EN
                err = 1'b1;
`endif
            end
        endcase
        return {err, v[XLEN-1:0]};
    endfunction

    // Model: a queue of expected {err, imm} entries.
    logic [XLEN:0] mq[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
        end else begin
            logic do_push, do_pop;
            logic [XLEN:0] nv;
            do_push = in_valid && (mq.size() < DEPTH);
            do_pop  = out_ready && (mq.size() > 0);
            nv      = ref_ext(in_instr, in_sel);
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(nv);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            chk("m_count", 64'(count), 64'(mq.size()));
            chk("m_out_valid", 64'(out_valid), 64'(mq.size() != 0));
            chk("m_in_ready", 64'(in_ready), 64'(mq.size() != DEPTH));
            if (mq.size() != 0) begin
                chk("m_out_imm", 64'(out_imm), 64'(mq[0][XLEN-1:0]));
                chk("m_out_err", 64'(out_err), 64'(mq[0][XLEN]));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Push one entry into an empty FIFO, check the head one cycle later, then drain it.
    task automatic push_and_check(input string name, input logic [31:0] instr,
                                  input logic [2:0] sel, input logic [XLEN-1:0] exp_imm,
                                  input logic exp_err);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = instr;
        in_sel    = sel;
        cyc();
        in_valid  = 1'b0;
        @(negedge clk);
        chk({name, "_valid"}, 64'(out_valid), 64'(1));
        chk({name, "_imm"}, 64'(out_imm), 64'(exp_imm));
        chk({name, "_err"}, 64'(out_err), 64'(exp_err));
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    logic chk_en_err;

    initial begin
`ifdef IMM_EXT_ILLEGAL_CHK_EN
        chk_en_err = 1'b1;
`else
        chk_en_err = 1'b0;
`endif
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_sel    = '0;
        out_ready = 1'b0;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_out_imm", 64'(out_imm), 64'(0));
        chk("rst_out_err", 64'(out_err), 64'(0));
        cyc();
        reset = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        cyc();

        // Single-format checks with hand-computed expectations.
        push_and_check("i_type", 32'hFFF0_0093, 3'b001, 32'hFFFF_FFFF, 1'b0);
        push_and_check("s_type", 32'hFE20_AE23, 3'b010, 32'hFFFF_FFFC, 1'b0);
        push_and_check("b_type", 32'hFE00_0CE3, 3'b011, 32'hFFFF_FFF8, 1'b0);
        push_and_check("u_type", 32'h1234_5037, 3'b100, 32'h1234_5000, 1'b0);
        push_and_check("j_type", 32'h0010_006F, 3'b101, 32'h0000_0800, 1'b0);
        push_and_check("shift", 32'h40F0_D093, 3'b110, 32'h0000_000F, 1'b0);
        push_and_check("sel_111", 32'hFFF0_0093, 3'b111, 32'h0, chk_en_err);
        push_and_check("sel_000", 32'hFFF0_0093, 3'b000, 32'h0, chk_en_err);
        push_and_check("shift_b25", 32'h43F0_D093, 3'b110,
                       chk_en_err ? 32'h0 : 32'h0000_001F, chk_en_err);

        // Backpressure: three back-to-back pushes into a two-entry FIFO.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hFFF0_0093; in_sel = 3'b001; cyc();
        in_instr  = 32'h1234_5037; in_sel = 3'b100; cyc();
        in_instr  = 32'h0010_006F; in_sel = 3'b101;
        @(negedge clk);
        chk("bp_full_count", 64'(count), 64'(2));
        chk("bp_full_in_ready", 64'(in_ready), 64'(0));
        cyc();
        @(negedge clk);
        chk("bp_held_count", 64'(count), 64'(2));
        chk("bp_head", 64'(out_imm), 64'(32'hFFFF_FFFF));
        out_ready = 1'b1;
        cyc();
        @(negedge clk);
        chk("bp_pop1_head", 64'(out_imm), 64'(32'h1234_5000));
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_third_head", 64'(out_imm), 64'(32'h0000_0800));
        chk("bp_third_count", 64'(count), 64'(1));
        cyc();
        @(negedge clk);
        chk("bp_drained", 64'(count), 64'(0));
        out_ready = 1'b0;

        // Simultaneous push and pop at count=1.
        in_valid = 1'b1; in_instr = 32'hFE20_AE23; in_sel = 3'b010;
        cyc();
        in_instr = 32'h40F0_D093; in_sel = 3'b110; out_ready = 1'b1;
        cyc();
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("sim_count", 64'(count), 64'(1));
        chk("sim_head", 64'(out_imm), 64'(32'h0000_000F));
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;

        // Asynchronous reset while the FIFO is full.
        in_valid = 1'b1; in_instr = 32'hFFF0_0093; in_sel = 3'b001;
        cyc();
        in_instr = 32'hFE00_0CE3; in_sel = 3'b011;
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_count", 64'(count), 64'(2));
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'(0));
        chk("async_rst_count", 64'(count), 64'(0));
        cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", 64'(out_valid), 64'(0));
        chk("post_rst_imm", 64'(out_imm), 64'(0));
        cyc();
        cyc();

        // Random traffic under the model only.
        for (int n = 0; n < 200; n++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_instr  = $urandom;
            in_sel    = 3'($urandom_range(0, 7));
            cyc();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/imm_ext_queue.md
Name: imm_ext_queue

Overview:
- Parametrised, pipelined successor to the combinational immediate extender.
- Accepts a raw 32-bit instruction plus format selector via valid/ready, extends the immediate to XLEN, and buffers results in a DEPTH-entry output FIFO.
- Sits between decode and the execute-stage operand mux, decoupling decode stalls from execute backpressure.
- Supports RV32 and RV64 immediate widths.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64 only.
- DEPTH, 2, output FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  clock, rising-edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  instruction/selector valid
- in_ready  output  1  block can accept this cycle
- in_instr  input  32  raw instruction word
- in_sel  input  3  format selector: 001 I, 010 S, 011 B, 100 U, 101 J, 110 shift-imm, 000/111 invalid
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer accepts head
- out_imm  output  XLEN  extended immediate at FIFO head
- out_err  output  1  head entry flagged illegal (see Optional Feature)
- count  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Single clock domain: clk. Reset is asynchronous, active-high on reset; all state clears immediately on assertion.
- Reset values: out_valid=0, count=0, out_imm=0, out_err=0; in_ready=1 once reset deasserts. Read/write pointers reset to 0.
- Extension is combinational on input fields; result is written into FIFO at the accepting edge.
- Push: in_valid && in_ready.
- Pop: out_valid && out_ready.
- Latency: push at edge N makes data visible at out_imm/out_valid after edge N when FIFO was empty (1-cycle). No combinational in->out path.
- in_ready = (count != DEPTH). It does not depend on out_ready, so there is no pass-through when full.
- out_valid = (count != 0). out_imm/out_err always show the head entry; value undefined-but-stable when empty (holds last).
- Simultaneous push and pop when 0 < count < DEPTH: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- out_imm must stay stable while out_valid && !out_ready.
- Formats (s = sign-extend to XLEN):
  - I = s(instr[31:20])
  - S = s({instr[31:25], instr[11:7]})
  - B = s({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})
  - U = s({instr[31:12], 12'b0}); sign-extended for RV64 LUI/AUIPC.
  - J = s({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})
  - shift-imm = zero-extended shamt: instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
  - Invalid selector (000/111) = 0.
- Reset mid-operation discards all buffered entries. Inputs presented during reset are ignored.

Optional Feature:
- Macro IMM_EXT_ILLEGAL_CHK_EN.
- When defined: out_err=1 for an entry whose in_sel was 000 or 111, or shift-imm with instr[25]=1 when XLEN=32. The error bit is stored per entry alongside the immediate; imm for such entries is 0.
- When undefined: out_err is tied to 0, no per-entry error storage, and invalid selectors still yield imm 0.

Test Plan:
- I-type: in_instr=0xFFF00093, sel=001 -> one cycle later out_valid=1, out_imm=0xFFFFFFFF (XLEN=64: 0xFFFFFFFFFFFFFFFF).
- S/B/U/J: 0xFE20AE23/010 -> 0xFFFFFFFC; 0xFE000CE3/011 -> 0xFFFFFFF8; 0x12345037/100 -> 0x12345000; 0x0010006F/101 -> 0x00000800.
- Shift: 0x40F0D093 sel=110 -> out_imm=0x0000000F. XLEN=64 with instr[25]=1 (0x43F0D093) -> 0x3F.
- Backpressure, DEPTH=2: out_ready=0, push 3 back-to-back -> in_ready=0 after 2nd accept, count=2, 3rd held. Raise out_ready -> heads pop in order, 3rd accepted, count reaches 0 after 3 pops.
- Simultaneous push/pop at count=1 -> count stays 1, order preserved. Reset asserted asynchronously with count=2 -> out_valid=0, count=0 immediately, no stale data after release.
- IMM_EXT_ILLEGAL_CHK_EN defined: sel=111 -> out_err=1, out_imm=0. Undefined: same stimulus -> out_err=0, out_imm=0.
